// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: loader, core data and core fetch share one port.
// Define ARB_RR_EN for round-robin core arbitration; the default build uses fixed dm-over-if priority.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int LD_HOLD = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_gnt,
    output logic          ld_rvalid,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          core_stall,
    output logic          ld_active
);

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] LOAD = 1'b1;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_LD   = 2'd1;
    localparam logic [1:0] OWN_DM   = 2'd2;
    localparam logic [1:0] OWN_IF   = 2'd3;

    localparam logic [7:0] HOLD_INIT = 8'(LD_HOLD);

    logic [0:0] state;
    logic [7:0] hold_cnt;
    logic [1:0] owner;
    logic       core_ok;
    logic       pref_dm;

`ifdef ARB_RR_EN
    // rr_ptr high means fetch has priority on the next contended cycle
    logic rr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (dm_gnt) begin
            rr_ptr <= 1'b1;
        end else if (if_gnt) begin
            rr_ptr <= 1'b0;
        end
    end

    assign pref_dm = ~rr_ptr;
`else
    assign pref_dm = 1'b1;
`endif

    // The loader is granted whenever it asks, in either state
    assign ld_gnt  = ld_req;
    assign core_ok = (state == RUN) && !ld_req;
    assign dm_gnt  = core_ok && dm_req && (!if_req || pref_dm);
    assign if_gnt  = core_ok && if_req && !dm_gnt;

    assign core_stall = (dm_req && !dm_gnt) || (if_req && !if_gnt);
    assign ld_active  = (state == LOAD);

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (ld_gnt) begin
            mem_we    = ld_we;
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
        end else if (dm_gnt) begin
            mem_we    = dm_we;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end else if (if_gnt) begin
            mem_addr  = if_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            hold_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (ld_gnt) begin
                        state    <= LOAD;
                        hold_cnt <= HOLD_INIT;
                    end
                end
                default: begin
                    if (ld_gnt) begin
                        hold_cnt <= HOLD_INIT;
                    end else if (hold_cnt <= 8'd1) begin
                        state    <= RUN;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt - 8'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner <= OWN_NONE;
        end else if (ld_gnt && !ld_we) begin
            owner <= OWN_LD;
        end else if (dm_gnt && !dm_we) begin
            owner <= OWN_DM;
        end else if (if_gnt) begin
            owner <= OWN_IF;
        end else begin
            owner <= OWN_NONE;
        end
    end

    assign ld_rvalid = (owner == OWN_LD);
    assign dm_rvalid = (owner == OWN_DM);
    assign if_rvalid = (owner == OWN_IF);
    assign rdata     = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a small registered memory model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_req, ld_we;
    logic [31:0] ld_addr, ld_wdata;
    logic        ld_gnt, ld_rvalid;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic        dm_gnt, dm_rvalid;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        core_stall, ld_active;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [31:0] mem [0:63];

    mem_port_arbiter #(.AW(32), .DW(32), .LD_HOLD(4)) dut (
        .clk(clk), .rst(rst),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .rdata(rdata), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .core_stall(core_stall), .ld_active(ld_active)
    );

    always #5 clk = ~clk;

    // Memory preloaded with 0x1000_0000 + index; read data valid one cycle after address
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + 32'(i);
            mem_rdata <= '0;
        end else begin
            if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;
            mem_rdata <= mem[mem_addr[5:0]];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ld_req = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0;
        dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
        if_req = 0; if_addr = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        cyc();
        cyc();
        rst = 0;
    endtask

    logic exp_dm;

    initial begin
        idle_inputs();
        do_reset();
        #1;
        check("rst_ld_active", 32'(ld_active), 0);
        check("rst_rvalids", {29'd0, ld_rvalid, dm_rvalid, if_rvalid}, 0);
        check("rst_stall", 32'(core_stall), 0);
        check("rst_mem_addr", mem_addr, 0);

        // Fetch read
        if_req = 1; if_addr = 5;
        #1;
        check("if_gnt", 32'(if_gnt), 1);
        check("if_mem_addr", mem_addr, 5);
        check("if_stall", 32'(core_stall), 0);
        cyc();
        if_req = 0;
        #1;
        check("if_rvalid", 32'(if_rvalid), 1);
        check("if_rdata", rdata, 32'h1000_0005);
        check("if_dm_rvalid", 32'(dm_rvalid), 0);

        // Data write contending with fetch
        dm_req = 1; dm_we = 1; dm_addr = 8; dm_wdata = 32'hDEAD_BEEF;
        if_req = 1; if_addr = 6;
        #1;
        check("dmw_gnt", 32'(dm_gnt), 1);
        check("dmw_if_gnt", 32'(if_gnt), 0);
        check("dmw_mem_we", 32'(mem_we), 1);
        check("dmw_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("dmw_stall", 32'(core_stall), 1);
        cyc();
        dm_req = 0; dm_we = 0;
        #1;
        check("after_w_if_gnt", 32'(if_gnt), 1);
        check("after_w_mem_we", 32'(mem_we), 0);
        check("w_no_rvalid", {29'd0, ld_rvalid, dm_rvalid, if_rvalid}, 0);
        cyc();
        if_req = 0;
        #1;
        check("if6_rdata", rdata, 32'h1000_0006);
        check("if6_rvalid", 32'(if_rvalid), 1);

        // Data read of the written word
        dm_req = 1; dm_addr = 8;
        #1;
        check("dmr_gnt", 32'(dm_gnt), 1);
        cyc();
        dm_req = 0;
        #1;
        check("dmr_rvalid", 32'(dm_rvalid), 1);
        check("dmr_rdata", rdata, 32'hDEAD_BEEF);

        // Loader: 3 writes with fetch pending
        if_req = 1; if_addr = 7;
        for (int i = 0; i < 3; i++) begin
            ld_req = 1; ld_we = 1; ld_addr = 20 + 32'(i); ld_wdata = 32'hA0 + 32'(i);
            #1;
            check("ld_gnt", 32'(ld_gnt), 1);
            check("ld_if_gnt", 32'(if_gnt), 0);
            check("ld_stall", 32'(core_stall), 1);
            check("ld_active_w", 32'(ld_active), (i == 0) ? 0 : 1);
            cyc();
        end
        // Two idle cycles, then a loader read reloads the hold counter
        ld_req = 0; ld_we = 0;
        cyc();
        cyc();
        #1;
        check("ld_hold_mid", 32'(ld_active), 1);
        ld_req = 1; ld_addr = 21;
        #1;
        check("ld_rd_gnt", 32'(ld_gnt), 1);
        check("ld_rd_mem_we", 32'(mem_we), 0);
        cyc();
        ld_req = 0;
        #1;
        check("ld_rvalid", 32'(ld_rvalid), 1);
        check("ld_rdata", rdata, 32'h0000_00A1);
        for (int i = 0; i < 4; i++) begin
            check("hold_active", 32'(ld_active), 1);
            check("hold_if_gnt", 32'(if_gnt), 0);
            check("hold_stall", 32'(core_stall), 1);
            cyc();
        end
        check("hold_done_active", 32'(ld_active), 0);
        check("hold_done_if_gnt", 32'(if_gnt), 1);
        check("hold_done_stall", 32'(core_stall), 0);
        cyc();
        if_req = 0;
        #1;
        check("if7_rvalid", 32'(if_rvalid), 1);
        check("if7_rdata", rdata, 32'h1000_0007);

        // Contended core requests from a fresh reset
        idle_inputs();
        do_reset();
        dm_req = 1; dm_addr = 20; if_req = 1; if_addr = 21;
        for (int i = 0; i < 6; i++) begin
            #1;
`ifdef ARB_RR_EN
            exp_dm = (i % 2 == 0);
`else
            exp_dm = 1'b1;
`endif
            check("arb_dm_gnt", 32'(dm_gnt), 32'(exp_dm));
            check("arb_if_gnt", 32'(if_gnt), 32'(!exp_dm));
            cyc();
        end

        // Reset arriving while a data read response is pending
        idle_inputs();
        cyc();
        dm_req = 1; dm_addr = 9;
        #1;
        check("pre_rst_dm_gnt", 32'(dm_gnt), 1);
        @(posedge clk);
        #1;
        rst = 1;
        dm_req = 0;
        #1;
        check("rst_mid_dm_rvalid", 32'(dm_rvalid), 0);
        check("rst_mid_ld_active", 32'(ld_active), 0);
        cyc();
        rst = 0;
        #1;
        check("post_rst_dm_rvalid", 32'(dm_rvalid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
